// File: rtl/mem_port_arbiter_if.sv
// Bundle of the I-cache, D-cache and main-memory line-transfer signals that
// meet at the shared memory-port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  // Handshake: a cache holds its read/write level (and address/data) until
  // its x_ready pulse, then drops or reissues it on the following cycle.
  // Memory strobes stay high until mem_ready, which completes the transfer.
  logic              ic_read;
  logic [ADDR_W-1:0] ic_addr;
  logic [DATA_W-1:0] ic_rdata;
  logic              ic_ready;

  logic              dc_read;
  logic              dc_write;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic [DATA_W-1:0] dc_rdata;
  logic              dc_ready;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport slave (
    input  ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata,
           mem_rdata, mem_ready,
    output ic_rdata, ic_ready, dc_rdata, dc_ready,
           mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output ic_read, ic_addr, dc_read, dc_write, dc_addr, dc_wdata,
           mem_rdata, mem_ready,
    input  ic_rdata, ic_ready, dc_rdata, dc_ready,
           mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises I-cache and D-cache line transfers onto the single main-memory
// port; round-robin or fixed D priority, plus a saturating conflict counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 128,
  parameter bit D_PRIORITY = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  mem_port_arbiter_if.slave bus,
  output logic [15:0] conflict_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic              last_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_write;

  logic i_req, d_req, both, pick_d, granted;

  assign i_req = bus.ic_read;
  assign d_req = bus.dc_read | bus.dc_write;
  assign both  = i_req & d_req;
  // On a conflict D wins under fixed priority, otherwise whoever did not win last.
  assign pick_d = d_req & (~i_req | D_PRIORITY | ~last_d);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_req | d_req) state_nxt = pick_d ? GNT_D : GNT_I;
      GNT_I,
      GNT_D:   if (bus.mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last_d       <= 1'b1;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      lat_write    <= 1'b0;
      conflict_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && (i_req | d_req)) begin
        last_d    <= pick_d;
        lat_addr  <= pick_d ? bus.dc_addr : bus.ic_addr;
        lat_wdata <= pick_d ? bus.dc_wdata : '0;
        lat_write <= pick_d & bus.dc_write;
      end
      if (state == IDLE && both && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // Memory side sees only latched values, and nothing at all while idle.
  assign granted       = (state != IDLE);
  assign bus.mem_read  = granted & ~lat_write;
  assign bus.mem_write = granted & lat_write;
  assign bus.mem_addr  = granted ? lat_addr : '0;
  assign bus.mem_wdata = (granted & lat_write) ? lat_wdata : '0;

  assign bus.ic_ready = (state == GNT_I) & bus.mem_ready;
  assign bus.dc_ready = (state == GNT_D) & bus.mem_ready;
  assign bus.ic_rdata = bus.ic_ready ? bus.mem_rdata : '0;
  assign bus.dc_rdata = bus.dc_ready ? bus.mem_rdata : '0;

  assign state_dbg = state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and
// a randomized run against a transaction-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW = 28;
  localparam int DW = 128;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1();
  logic [15:0] cnt0, cnt1;
  logic [1:0]  st0, st1;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1'b0)) dut0 (
    .clk(clk), .rst(rst), .bus(m0.slave), .conflict_cnt(cnt0), .state_dbg(st0));
  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .D_PRIORITY(1'b1)) dut1 (
    .clk(clk), .rst(rst), .bus(m1.slave), .conflict_cnt(cnt1), .state_dbg(st1));

  int n_cmp = 0;
  int n_bad = 0;
  int mem_dly = 1;
  bit mem_rand = 1'b0;
  bit mem_spur = 1'b0;
  int rc0 = -1;
  int rc1 = -1;

  // expected memory transaction: {write, addr, wdata}
  logic [DW+AW:0] exp_q[$];

  typedef struct {
    logic          ic_r, dc_r, dc_w;
    logic          e_rd, e_wr, e_i, e_d;
    logic [15:0]   e_cnt;
    logic [AW-1:0] ia, da;
    logic [DW-1:0] dw;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic clr_inputs();
    m0.ic_read = 0; m0.ic_addr = '0; m0.dc_read = 0; m0.dc_write = 0;
    m0.dc_addr = '0; m0.dc_wdata = '0;
    m1.ic_read = 0; m1.ic_addr = '0; m1.dc_read = 0; m1.dc_write = 0;
    m1.dc_addr = '0; m1.dc_wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // memory models: answer each strobe after a delay, optionally with stray readies
  always begin
    @(posedge clk); #1;
    if (!rst) begin
      m0.mem_ready = 1'b0; rc0 = -1;
    end else if (m0.mem_ready) begin
      m0.mem_ready = 1'b0;
    end else if (m0.mem_read || m0.mem_write) begin
      if (rc0 < 0) rc0 = mem_rand ? int'($urandom_range(0, 3)) : mem_dly;
      if (rc0 == 0) begin
        m0.mem_ready = 1'b1; m0.mem_rdata = rnd128(); rc0 = -1;
      end else rc0--;
    end else begin
      rc0 = -1;
      if (mem_spur && $urandom_range(0, 7) == 0) begin
        m0.mem_ready = 1'b1; m0.mem_rdata = rnd128();
      end
    end
  end

  always begin
    @(posedge clk); #1;
    if (!rst) begin
      m1.mem_ready = 1'b0; rc1 = -1;
    end else if (m1.mem_ready) begin
      m1.mem_ready = 1'b0;
    end else if (m1.mem_read || m1.mem_write) begin
      if (rc1 < 0) rc1 = mem_dly;
      if (rc1 == 0) begin
        m1.mem_ready = 1'b1; m1.mem_rdata = rnd128(); rc1 = -1;
      end else rc1--;
    end else rc1 = -1;
  end

  initial begin
    #2_000_000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]     got[3];
    logic [1:0]     exp_g;
    int             ng;
    bit             seen;
    logic [AW-1:0]  e_addr;
    logic [DW+AW:0] e;
    int             own, last;
    int             mcnt;
    bit             i_drop, d_drop;
    int             op;

    // vectors: ic_r dc_r dc_w | e_rd e_wr e_i e_d e_cnt | ia da dw
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0, 28'h20,  28'h0,  128'h0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd0, 28'h0,   28'h80, 128'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 28'h0,   28'h80, 128'h1234};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'd0, 28'h0,   28'h3c, 128'hbeef};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 28'h11,  28'h22, 128'h0};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1, 28'h33,  28'h44, 128'h55};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 28'h66,  28'h77, 128'h0};

    m0.mem_ready = 0; m0.mem_rdata = '0; m1.mem_ready = 0; m1.mem_rdata = '0;
    rst = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    chk("rst_mem_read", m0.mem_read, 0);
    chk("rst_mem_write", m0.mem_write, 0);
    chk("rst_mem_addr", m0.mem_addr, 0);
    chk("rst_ic_ready", m0.ic_ready, 0);
    chk("rst_dc_ready", m0.dc_ready, 0);
    chk("rst_conflict", cnt0, 0);
    chk("rst_state", st0, 0);
    rst = 1'b1;

    // ---------------- vector table ----------------
    mem_dly = 1;
    for (int i = 0; i < 7; i++) begin
      do_reset();
      step();
      m0.ic_read = tbl[i].ic_r; m0.ic_addr = tbl[i].ia;
      m0.dc_read = tbl[i].dc_r; m0.dc_write = tbl[i].dc_w;
      m0.dc_addr = tbl[i].da;   m0.dc_wdata = tbl[i].dw;
      @(negedge clk);
      chk("tbl_latency", m0.mem_read | m0.mem_write, 0);
      step(); @(negedge clk);
      e_addr = tbl[i].e_i ? tbl[i].ia : (tbl[i].e_d ? tbl[i].da : '0);
      chk($sformatf("tbl%0d_mem_read", i), m0.mem_read, tbl[i].e_rd);
      chk($sformatf("tbl%0d_mem_write", i), m0.mem_write, tbl[i].e_wr);
      chk($sformatf("tbl%0d_mem_addr", i), m0.mem_addr, e_addr);
      if (tbl[i].e_wr) chk($sformatf("tbl%0d_mem_wdata", i), m0.mem_wdata, tbl[i].dw);
      step(); @(negedge clk);
      chk($sformatf("tbl%0d_ic_ready", i), m0.ic_ready, tbl[i].e_i);
      chk($sformatf("tbl%0d_dc_ready", i), m0.dc_ready, tbl[i].e_d);
      chk($sformatf("tbl%0d_ic_rdata", i), m0.ic_rdata, tbl[i].e_i ? m0.mem_rdata : '0);
      chk($sformatf("tbl%0d_dc_rdata", i), m0.dc_rdata, tbl[i].e_d ? m0.mem_rdata : '0);
      chk($sformatf("tbl%0d_conflict", i), cnt0, tbl[i].e_cnt);
      clr_inputs();
    end

    // ---------------- single I read, exact timing ----------------
    do_reset();
    mem_dly = 3;
    step();
    m0.ic_read = 1; m0.ic_addr = 28'h20;
    @(negedge clk);
    chk("ird_t0_read", m0.mem_read, 0);
    for (int k = 1; k <= 4; k++) begin
      step(); @(negedge clk);
      chk($sformatf("ird_t%0d_read", k), m0.mem_read, 1);
      chk($sformatf("ird_t%0d_addr", k), m0.mem_addr, 28'h20);
      chk($sformatf("ird_t%0d_ic_ready", k), m0.ic_ready, k == 4);
      chk($sformatf("ird_t%0d_dc_ready", k), m0.dc_ready, 0);
    end
    chk("ird_rdata", m0.ic_rdata, m0.mem_rdata);
    m0.ic_read = 0;
    step(); @(negedge clk);
    chk("ird_after_read", m0.mem_read, 0);
    chk("ird_after_state", st0, 0);

    // ---------------- continuous dual demand: round robin, then D priority ----------------
    for (int sel = 0; sel < 2; sel++) begin
      do_reset();
      mem_dly = 0;
      step();
      if (sel == 0) begin
        m0.ic_read = 1; m0.ic_addr = 28'h100; m0.dc_read = 1; m0.dc_addr = 28'h200;
      end else begin
        m1.ic_read = 1; m1.ic_addr = 28'h100; m1.dc_read = 1; m1.dc_addr = 28'h200;
      end
      ng = 0;
      for (int c = 0; c < 40 && ng < 3; c++) begin
        @(negedge clk);
        exp_g = (sel == 0) ? {m0.ic_ready, m0.dc_ready} : {m1.ic_ready, m1.dc_ready};
        if (exp_g != 2'b00) begin
          got[ng] = exp_g;
          ng++;
        end
      end
      chk(sel ? "prio_grants" : "rr_grants", ng, 3);
      for (int k = 0; k < ng; k++) begin
        exp_g = (sel == 1) ? 2'b01 : ((k % 2 == 0) ? 2'b10 : 2'b01);
        chk($sformatf("%s_order%0d", sel ? "prio" : "rr", k), got[k], exp_g);
      end
      chk(sel ? "prio_conflict" : "rr_conflict", sel ? cnt1 : cnt0, 3);
      clr_inputs();
    end

    // ---------------- D read+write held, address change mid-grant ----------------
    do_reset();
    mem_dly = 3;
    step();
    m0.dc_read = 1; m0.dc_write = 1; m0.dc_addr = 28'h80; m0.dc_wdata = 128'h1234;
    @(negedge clk);
    step(); @(negedge clk);
    chk("dwr_write", m0.mem_write, 1);
    chk("dwr_read", m0.mem_read, 0);
    chk("dwr_addr", m0.mem_addr, 28'h80);
    chk("dwr_wdata", m0.mem_wdata, 128'h1234);
    m0.dc_addr = 28'h99; m0.dc_wdata = 128'hdead;
    step(); @(negedge clk);
    chk("dwr_hold_addr", m0.mem_addr, 28'h80);
    chk("dwr_hold_wdata", m0.mem_wdata, 128'h1234);
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step(); @(negedge clk);
      if (m0.dc_ready) seen = 1;
    end
    chk("dwr_dc_ready", seen, 1);
    chk("dwr_ic_ready", m0.ic_ready, 0);
    clr_inputs();
    step(); @(negedge clk);
    chk("dwr_idle_state", st0, 0);
    chk("dwr_idle_write", m0.mem_write, 0);

    // ---------------- reset during a D write ----------------
    do_reset();
    mem_dly = 1;
    step();
    m0.ic_read = 1; m0.ic_addr = 28'h44;
    m0.dc_write = 1; m0.dc_addr = 28'h88; m0.dc_wdata = 128'h5;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m0.ic_ready) begin seen = 1; m0.ic_read = 0; end
    end
    chk("rmid_i_first", seen, 1);
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (m0.mem_write) seen = 1;
    end
    chk("rmid_d_granted", seen, 1);
    chk("rmid_conflict_pre", cnt0, 1);
    m0.ic_read = 1;
    rst = 1'b0;
    #1;
    chk("rmid_write_drop", m0.mem_write, 0);
    chk("rmid_conflict", cnt0, 0);
    chk("rmid_state", st0, 0);
    m0.dc_write = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rmid_i_regrant", m0.mem_read, 1);
    chk("rmid_i_addr", m0.mem_addr, 28'h44);
    clr_inputs();

    // ---------------- randomized run against a transfer-level model ----------------
    do_reset();
    mem_rand = 1; mem_spur = 1;
    exp_q.delete();
    own = 0; last = 2; mcnt = 0; i_drop = 0; d_drop = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      if (i_drop) begin
        i_drop = 0;
        if ($urandom_range(0, 1) == 0) m0.ic_read = 0;
        else m0.ic_addr = AW'($urandom);
      end else if (!m0.ic_read && $urandom_range(0, 2) == 0) begin
        m0.ic_read = 1; m0.ic_addr = AW'($urandom);
      end
      if (d_drop || (!m0.dc_read && !m0.dc_write && $urandom_range(0, 2) == 0)) begin
        if (d_drop && $urandom_range(0, 1) == 0) begin
          m0.dc_read = 0; m0.dc_write = 0;
        end else begin
          op = int'($urandom_range(0, 2));
          m0.dc_read = (op != 1); m0.dc_write = (op != 0);
          m0.dc_addr = AW'($urandom); m0.dc_wdata = rnd128();
        end
        d_drop = 0;
      end
      @(negedge clk);
      chk("rnd_conflict", cnt0, mcnt);
      if (own != 0) begin
        e = exp_q[0];
        chk("rnd_mem_write", m0.mem_write, e[DW+AW]);
        chk("rnd_mem_read", m0.mem_read, !e[DW+AW]);
        chk("rnd_mem_addr", m0.mem_addr, e[DW+AW-1:DW]);
        if (e[DW+AW]) chk("rnd_mem_wdata", m0.mem_wdata, e[DW-1:0]);
        if (m0.mem_ready) begin
          chk("rnd_ic_ready", m0.ic_ready, own == 1);
          chk("rnd_dc_ready", m0.dc_ready, own == 2);
          chk("rnd_ic_rdata", m0.ic_rdata, (own == 1) ? m0.mem_rdata : '0);
          chk("rnd_dc_rdata", m0.dc_rdata, (own == 2) ? m0.mem_rdata : '0);
          void'(exp_q.pop_front());
          if (own == 1) i_drop = 1; else d_drop = 1;
          own = 0;
        end else begin
          chk("rnd_busy_readies", {m0.ic_ready, m0.dc_ready}, 2'b00);
        end
      end else begin
        chk("rnd_idle_strobes", {m0.mem_read, m0.mem_write}, 2'b00);
        chk("rnd_idle_readies", {m0.ic_ready, m0.dc_ready}, 2'b00);
        if (m0.ic_read && (m0.dc_read || m0.dc_write)) begin
          if (mcnt < 65535) mcnt++;
          own = (last == 1) ? 2 : 1;
        end else if (m0.ic_read) own = 1;
        else if (m0.dc_read || m0.dc_write) own = 2;
        if (own == 1) exp_q.push_back({1'b0, m0.ic_addr, {DW{1'b0}}});
        if (own == 2) exp_q.push_back({m0.dc_write, m0.dc_addr, m0.dc_wdata});
        if (own != 0) last = own;
      end
    end
    mem_rand = 0; mem_spur = 0;

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single slow main-memory port between the I-cache (read-only) and the D-cache (read/write) of the pipelined CPU.
- Sits between both caches' memory-side interfaces and the memory model.
- Serialises line transfers with a grant FSM: round-robin or fixed D-cache priority.
- Exposes a saturating conflict counter for the performance report.

Parameters:
ADDR_W, 28, line-address width (word address minus 2-bit word offset within a 4-word line)
DATA_W, 128, line width in bits
D_PRIORITY, 0, 0 = round-robin between requesters; 1 = D-cache always wins a conflict

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ic_read  in  1  I-cache line-read request, level, held until ic_ready
ic_addr  in  ADDR_W  I-cache line address
ic_rdata  out  DATA_W  line data to I-cache
ic_ready  out  1  I-cache transfer complete, 1-cycle pulse
dc_read  in  1  D-cache line-read request, level
dc_write  in  1  D-cache line-write request, level
dc_addr  in  ADDR_W  D-cache line address
dc_wdata  in  DATA_W  D-cache write line
dc_rdata  out  DATA_W  line data to D-cache
dc_ready  out  1  D-cache transfer complete, 1-cycle pulse
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  ADDR_W  memory line address
mem_wdata  out  DATA_W  memory write line
mem_rdata  in  DATA_W  memory read line
mem_ready  in  1  memory transfer complete
conflict_cnt  out  16  cycles in IDLE with both requesters pending, saturating

Behaviour:
- FSM states: IDLE, GNT_I, GNT_D.
- Reset (async, rst=0): state IDLE, last_grant=D (so I-cache wins the first round-robin conflict), conflict_cnt=0, latched addr/wdata/op=0. All outputs 0 while in reset.
- IDLE:
  - Samples requests. A D request is dc_read|dc_write.
  - Only one requester pending: grant it.
  - Both pending: if D_PRIORITY=1, grant D; else grant the one not equal to last_grant. conflict_cnt += 1, saturating at 16'hFFFF.
  - On grant: latch address, wdata and op into registers. Next state GNT_x. Update last_grant.
  - No request: stay IDLE.
- GNT_x:
  - mem_read/mem_write/mem_addr/mem_wdata are driven only from the latched registers.
  - Memory signals are asserted from the cycle after the request is sampled. Arbiter adds 1 cycle of request latency.
  - Strobes are held until mem_ready.
  - In the mem_ready cycle: x_ready=1 combinationally, and x_rdata=mem_rdata (reads; also passed through on writes, contents don't-care). Next state IDLE.
- Response latency: request at cycle t, memory responds at cycle r ≥ t+1, so x_ready is asserted at cycle r.
- Requesters must drop the request the cycle after x_ready. IDLE re-samples at that cycle, so back-to-back grants are separated by exactly one IDLE cycle.
- Non-granted requester: x_ready=0, x_rdata=0. A request held in GNT of the other requester is serviced at the next IDLE.
- dc_read and dc_write both high: treated as a write. mem_read=0, mem_write=1.
- mem_read and mem_write are never both 1. Memory strobes are 0 in IDLE.
- Request changes during GNT (address/data) are ignored; only latched values are used.
- mem_ready while in IDLE: ignored; no ready pulse.
- Reset mid-transfer: return to IDLE immediately and drop strobes; the in-flight request is lost, and the cache reissues it after reset.
- Starvation-free when D_PRIORITY=0. Under continuous dual demand, grants strictly alternate.

Test Plan:
- Single I read: ic_read=1, ic_addr=28'h20 at t0; mem_ready at t0+4 with mem_rdata=128'hA5.. -> mem_read=1, mem_addr=28'h20 during t0+1..t0+4; ic_ready=1 at t0+4 only, ic_rdata=128'hA5..; dc_ready stays 0.
- D write: dc_write=1, dc_addr=28'h80, dc_wdata=128'h1234 -> mem_write=1, mem_wdata=128'h1234, mem_read=0; dc_ready pulse on mem_ready; state back to IDLE the next cycle.
- Round-robin conflict after reset (D_PRIORITY=0): ic_read and dc_read both held -> I granted first, then D, then I. conflict_cnt=1, then increments once per conflicting IDLE cycle.
- D_PRIORITY=1 with both requesting continuously for 3 transfers -> D granted every time, I never granted while D is held.
- Both dc_read=1 and dc_write=1 -> mem_write=1, mem_read=0. Changing dc_addr mid-grant leaves mem_addr at the latched value.
- Reset asserted during GNT_D with mem_write=1 -> mem_write=0 immediately, conflict_cnt=0. After reset release, a pending ic_read is granted on the first clock.
